mem_io_responder: RTL



---
 rtl/mem_io_responder_pkg.sv | 27 ++
 rtl/mem_io_responder_byte_fifo.sv | 56 +++++
 rtl/mem_io_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants, address decode and access kinds for the
// memory/I-O responder on the CPU byte bus.
package mem_io_responder_pkg;

  localparam int RAM_AW    = 17;
  localparam int RAM_BYTES = 1 << RAM_AW;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [2:0]  IO_UART = 3'd0;
  localparam logic [2:0]  IO_CLK  = 3'd4;

  typedef enum logic [2:0] {
    ACC_IDLE,
    ACC_RAM_RD,
    ACC_RAM_WR,
    ACC_RX_POP,
    ACC_TX_PUSH,
    ACC_CLK_RD,
    ACC_SNAP_RD,
    ACC_STOP
  } acc_e;

  function automatic logic is_io(input logic [1:0] a_hi);
    return a_hi == IO_BASE[17:16];
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with show-ahead read; a push into a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [7:0]             data_i,
  output logic [7:0]             data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ONE;
    if (do_pop)  rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Bus responder: byte RAM plus I/O window with UART FIFOs,
// cycle counter with coherent snapshot, and program-stop latch.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W  = RAM_AW,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [7:0]            ram_q [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic [2:0]            io_sub;
  logic                  io_sel;
  acc_e                  acc;

  logic [31:0] cnt_q;
  logic [31:0] snap_q, snap_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        stop_q, stop_d;
  logic        ovf_q, ovf_d;
  logic        ram_we;

  logic           tx_push, tx_pop;
  logic           tx_full, tx_empty;
  logic [7:0]     tx_din;
  logic [TCW-1:0] tx_count, tx_free;

  logic           rx_push, rx_pop;
  logic           rx_full, rx_empty;
  logic [7:0]     rx_dout;
  logic [RCW-1:0] rx_count;

  logic unused_ok;

  assign ram_idx = mem_a[RAM_ADDR_W-1:0];
  assign io_sub  = mem_a[2:0];
  assign io_sel  = is_io(mem_a[17:16]);

  assign unused_ok = ^{mem_a[31:18], rx_count};

  always_comb begin
    acc = ACC_IDLE;
    unique case (1'b1)
      (!io_sel && !mem_wr):
        acc = ACC_RAM_RD;
      (!io_sel && mem_wr):
        acc = ACC_RAM_WR;
      (io_sel && !mem_wr && io_sub == IO_UART):
        acc = ACC_RX_POP;
      (io_sel && mem_wr && io_sub == IO_UART &&
       mem_wdata != 8'h00):
        acc = ACC_TX_PUSH;
      (io_sel && !mem_wr && io_sub == IO_CLK):
        acc = ACC_CLK_RD;
      (io_sel && !mem_wr && io_sub[2] &&
       io_sub[1:0] != 2'b00):
        acc = ACC_SNAP_RD;
      (io_sel && mem_wr && io_sub == IO_CLK):
        acc = ACC_STOP;
      default:
        acc = ACC_IDLE;
    endcase
  end

  assign tx_pop  = !tx_empty && tx_ready;
  assign rx_push = rx_valid && !rx_full;

  always_comb begin
    rdata_d = rdata_q;
    snap_d  = snap_q;
    stop_d  = stop_q;
    ovf_d   = ovf_q;
    ram_we  = 1'b0;
    tx_push = 1'b0;
    tx_din  = mem_wdata;
    rx_pop  = 1'b0;
    if (rdy_in) begin
      rdata_d = 8'h00;
      unique case (acc)
        ACC_RAM_RD: rdata_d = ram_q[ram_idx];
        ACC_RAM_WR: ram_we = 1'b1;
        ACC_RX_POP: begin
          if (!rx_empty) begin
            rx_pop  = 1'b1;
            rdata_d = rx_dout;
          end
        end
        ACC_TX_PUSH: tx_push = 1'b1;
        ACC_CLK_RD: begin
          rdata_d = cnt_q[7:0];
          snap_d  = cnt_q;
        end
        ACC_SNAP_RD: begin
          unique case (io_sub[1:0])
            2'd1:    rdata_d = snap_q[15:8];
            2'd2:    rdata_d = snap_q[23:16];
            default: rdata_d = snap_q[31:24];
          endcase
        end
        ACC_STOP: begin
          stop_d  = 1'b1;
          tx_push = 1'b1;
          tx_din  = 8'h00;
        end
        default: ;
      endcase
      // A push into a full FIFO survives only if the UART pops now.
      if (tx_push && tx_full && !tx_pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      snap_q  <= '0;
      rdata_q <= '0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 32'd1;
      snap_q  <= snap_d;
      rdata_q <= rdata_d;
      stop_q  <= stop_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_idx] <= mem_wdata;
  end

  byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .data_i  (tx_din),
    .data_o  (tx_data),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  byte_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (rx_data),
    .data_o  (rx_dout),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign tx_free        = TCW'(TX_DEPTH) - tx_count;
  assign io_buffer_full = tx_free <= TCW'(FULL_MARGIN);

  assign mem_rdata    = rdata_q;
  assign tx_valid     = !tx_empty;
  assign rx_ready     = !rx_full;
  assign program_stop = stop_q;
  assign tx_overflow  = ovf_q;

endmodule
